calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Top-level sequencer for the calculator datapath. It owns the 3-bit `state` bus that steers the operand/operation mux, and latches operand A, operand B and the operation code from the 16-bit `op` bus on each EXE. It starts the ALU, waits a fixed latency, captures the result, and clears the digit shift register between entries through `rst_s`. It sits between the cursor/detector input path and the ALU/display.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width; equals the `op` bus width.
- `OPW`, 5: operation code width.
- `OP_COUNT`, 8: valid operation codes are 0..OP_COUNT-1.
- `ALU_LAT`, 2: ALU latency in cycles, minimum 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `EXE` in 1: execute pulse from the detector, one cycle wide.
- `CLR` in 1: clear-all pulse, one cycle wide.
- `CE` in 1: clear-entry pulse, one cycle wide.
- `op` in WIDTH: mux output; shows the shift-register number or the zero-extended operation code.
- `alu_result` in WIDTH: ALU output.
- `state` out 3: mux select and FSM state.
- `rst_s` out 1: one-cycle clear pulse to the shift register.
- `alu_start` out 1: one-cycle ALU start pulse.
- `reg_a`, `reg_b` out WIDTH: latched operands.
- `reg_op` out OPW: latched operation.
- `result` out WIDTH: latched ALU result.
- `result_valid` out 1: high while in S_RES.

## Operation
- State encoding: S_A=0, S_B=1, S_OP=2, S_CALC=3, S_RES=4. Codes 5..7 are illegal and go to S_A on the next edge with `rst_s` pulsed.
- Reset values:
  - `state` = S_A.
  - All registers 0.
  - `rst_s`, `alu_start`, `result_valid` = 0.
- Input priority within a cycle: CLR > CE > EXE. Lower-priority inputs in the same cycle are ignored.
- CLR in any state:
  - Go to S_A.
  - Clear `reg_a`, `reg_b`, `reg_op`, `result` and the latency counter.
  - Pulse `rst_s`.
- CE:
  - S_A, S_B, S_OP: pulse `rst_s`, state unchanged, registers unchanged.
  - S_CALC, S_RES: ignored.
- S_A + EXE: `reg_a` <= `op`, pulse `rst_s`, go to S_B.
- S_B + EXE: `reg_b` <= `op`, pulse `rst_s`, go to S_OP.
- S_OP + EXE:
  - If `op[OPW-1:0]` < OP_COUNT: `reg_op` <= code, pulse `rst_s`, go to S_CALC.
  - Otherwise: stay in S_OP and leave `reg_op` unchanged.
- S_CALC:
  - `alu_start` is high in the first cycle only.
  - A counter runs 0..ALU_LAT-1. EXE is ignored.
  - When the count reaches ALU_LAT-1: `result` <= `alu_result`, go to S_RES.
- S_RES: `result_valid` = 1. EXE behaviour is set in Configuration.
- `rst_s` is never asserted for two consecutive cycles by a single event. Two back-to-back accepted events give two back-to-back pulses.

## Timing
- All outputs are registered, so there are no combinational paths from inputs to outputs.
- EXE accepted on edge k:
  - `state` and the latched register are updated at edge k.
  - `rst_s` is high for exactly cycle k→k+1.
- `alu_start` is high during the first S_CALC cycle, N.
- `alu_result` is sampled on the edge ending cycle N+ALU_LAT-1.
- `state` = S_RES and `result_valid` = 1 from cycle N+ALU_LAT. With ALU_LAT=1, S_RES begins the cycle after `alu_start`.
- CLR during S_CALC aborts the calculation: no result is captured, and `alu_start` is not reissued.
- Reset mid-operation: all outputs return to reset values on the same edge. Reset overrides CLR, CE and EXE.

## Configuration
- `CALC_CHAIN_EN` defined:
  - EXE in S_RES sets `reg_a` <= `result` and `reg_b` <= 0, pulses `rst_s`, and goes to S_B. This allows chained operations.
- `CALC_CHAIN_EN` undefined:
  - EXE in S_RES behaves exactly like CLR: go to S_A, clear all registers, pulse `rst_s`.
- CE and CLR behaviour is identical in both builds.

## Test plan
- Basic calculation, ALU_LAT=2, ALU model = add:
  - Stimulus: `op`=12 + EXE, `op`=34 + EXE, `op`=0 + EXE.
  - Required: `rst_s` pulses after each EXE; `state` goes 0→1→2→3; `alu_start` high one cycle; `result`=46 and `state`=4 exactly 2 cycles after `alu_start`.
- Invalid operation:
  - Stimulus: in S_OP, `op`=9 + EXE (OP_COUNT=8).
  - Required: `state` stays 2, `reg_op` unchanged, no `rst_s`, no `alu_start`.
- Abort during calculation:
  - Stimulus: CLR in the second S_CALC cycle.
  - Required: `state`=0 on the next edge; `result`=0; `result_valid` never asserts; `rst_s` one pulse.
- Simultaneous inputs in S_B:
  - Stimulus: CE+EXE in the same cycle.
  - Required: `rst_s` pulses, `state` stays 1, `reg_b` unchanged.
  - Stimulus: CLR+EXE in the same cycle.
  - Required: `state`=0, all registers 0.
- Chaining with `CALC_CHAIN_EN`:
  - Stimulus: EXE in S_RES with `result`=46.
  - Required: `reg_a`=46, `state`=1.
- Chaining without `CALC_CHAIN_EN`:
  - Stimulus: EXE in S_RES.
  - Required: `state`=0, `reg_a`=0.
- Reset mid-operation:
  - Stimulus: `rst` asserted in S_CALC.
  - Required: all outputs at reset values the following cycle; no `alu_start` afterwards.

Source files
------------

// File: rtl/calc_sequencer.sv
// Calculator sequencer: latches operands/op, runs the ALU, captures result.
// Optional CALC_CHAIN_EN: EXE in S_RES chains the result into operand A.
module calc_sequencer #(
    parameter int WIDTH    = 16,
    parameter int OPW      = 5,
    parameter int OP_COUNT = 8,
    parameter int ALU_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EXE,
    input  logic             CLR,
    input  logic             CE,
    input  logic [WIDTH-1:0] op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [2:0]       state,
    output logic             rst_s,
    output logic             alu_start,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [OPW-1:0]   reg_op,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ALU_LAT - 1);

    state_t           st, nxt_st;
    logic [CW-1:0]    cnt, nxt_cnt;
    logic [WIDTH-1:0] nxt_a, nxt_b, nxt_res;
    logic [OPW-1:0]   nxt_op;
    logic             nxt_rst_s, nxt_start, nxt_valid;
    logic             clr_all;
    logic             op_ok;

    assign op_ok = 32'(op[OPW-1:0]) < OP_COUNT;
    assign state = st;

    always_comb begin
        nxt_st    = st;
        nxt_cnt   = cnt;
        nxt_a     = reg_a;
        nxt_b     = reg_b;
        nxt_op    = reg_op;
        nxt_res   = result;
        nxt_rst_s = 1'b0;
        nxt_start = 1'b0;
        clr_all   = CLR;
        unique case (st)
            S_A: begin
                if (CE) begin
                    nxt_rst_s = 1'b1;
                end else if (EXE) begin
                    nxt_a     = op;
                    nxt_rst_s = 1'b1;
                    nxt_st    = S_B;
                end
            end
            S_B: begin
                if (CE) begin
                    nxt_rst_s = 1'b1;
                end else if (EXE) begin
                    nxt_b     = op;
                    nxt_rst_s = 1'b1;
                    nxt_st    = S_OP;
                end
            end
            S_OP: begin
                if (CE) begin
                    nxt_rst_s = 1'b1;
                end else if (EXE && op_ok) begin
                    nxt_op    = op[OPW-1:0];
                    nxt_rst_s = 1'b1;
                    nxt_start = 1'b1;
                    nxt_cnt   = '0;
                    nxt_st    = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == LAST) begin
                    nxt_res = alu_result;
                    nxt_cnt = '0;
                    nxt_st  = S_RES;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            S_RES: begin
                if (EXE && !CE) begin
`ifdef CALC_CHAIN_EN
                    nxt_a     = result;
                    nxt_b     = '0;
                    nxt_rst_s = 1'b1;
                    nxt_st    = S_B;
`else
                    clr_all   = 1'b1;
`endif
                end
            end
            default: begin
                nxt_st    = S_A;
                nxt_rst_s = 1'b1;
            end
        endcase
        // CLR (or unchained EXE in S_RES) wins over anything decided above
        if (clr_all) begin
            nxt_st    = S_A;
            nxt_cnt   = '0;
            nxt_a     = '0;
            nxt_b     = '0;
            nxt_op    = '0;
            nxt_res   = '0;
            nxt_rst_s = 1'b1;
            nxt_start = 1'b0;
        end
        nxt_valid = (nxt_st == S_RES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= S_A;
            cnt          <= '0;
            reg_a        <= '0;
            reg_b        <= '0;
            reg_op       <= '0;
            result       <= '0;
            rst_s        <= 1'b0;
            alu_start    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            st           <= nxt_st;
            cnt          <= nxt_cnt;
            reg_a        <= nxt_a;
            reg_b        <= nxt_b;
            reg_op       <= nxt_op;
            result       <= nxt_res;
            rst_s        <= nxt_rst_s;
            alu_start    <= nxt_start;
            result_valid <= nxt_valid;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: vector table through a scoreboard queue,
// plus a hand-written reset-during-calculation sequence.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE, CLR, CE;
    logic [15:0] op;
    logic [15:0] alu_result;
    logic [2:0]  state;
    logic        rst_s, alu_start, result_valid;
    logic [15:0] reg_a, reg_b, result;
    logic [4:0]  reg_op;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // ALU model: adder
    assign alu_result = reg_a + reg_b;

    calc_sequencer #(
        .WIDTH(16), .OPW(5), .OP_COUNT(8), .ALU_LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .EXE(EXE), .CLR(CLR), .CE(CE),
        .op(op), .alu_result(alu_result), .state(state),
        .rst_s(rst_s), .alu_start(alu_start),
        .reg_a(reg_a), .reg_b(reg_b), .reg_op(reg_op),
        .result(result), .result_valid(result_valid)
    );

    typedef struct {
        logic        clr, ce, exe;
        logic [15:0] op;
        logic [2:0]  st;
        logic        rs, start, valid;
        logic [15:0] a, b;
        logic [4:0]  opc;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(
        logic clr, logic ce, logic exe, logic [15:0] o,
        logic [2:0] st, logic rs, logic start, logic valid,
        logic [15:0] a, logic [15:0] b, logic [4:0] opc,
        logic [15:0] res);
        vec_t v;
        v.clr = clr; v.ce = ce; v.exe = exe; v.op = o;
        v.st = st; v.rs = rs; v.start = start; v.valid = valid;
        v.a = a; v.b = b; v.opc = opc; v.res = res;
        return v;
    endfunction

    task automatic chk(string nm, int row,
                       logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %0d want %0d",
                     nm, row, act, exp);
        end
    endtask

    task automatic idle_in();
        CLR = 1'b0; CE = 1'b0; EXE = 1'b0; op = '0;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        idle_in();
        //       clr ce exe op    st rs stt v  a    b    opc res
        vecs.push_back(mk(0,0,0, 0,   0,0,0,0, 0,  0,  0, 0));
        vecs.push_back(mk(0,0,1, 12,  1,1,0,0, 12, 0,  0, 0));
        vecs.push_back(mk(0,0,0, 0,   1,0,0,0, 12, 0,  0, 0));
        vecs.push_back(mk(0,0,1, 34,  2,1,0,0, 12, 34, 0, 0));
        vecs.push_back(mk(0,0,1, 9,   2,0,0,0, 12, 34, 0, 0));
        vecs.push_back(mk(0,0,1, 0,   3,1,1,0, 12, 34, 0, 0));
        vecs.push_back(mk(0,0,1, 5,   3,0,0,0, 12, 34, 0, 0));
        vecs.push_back(mk(0,0,0, 0,   4,0,0,1, 12, 34, 0, 46));
`ifdef CALC_CHAIN_EN
        vecs.push_back(mk(0,0,1, 0,   1,1,0,0, 46, 0,  0, 46));
`else
        vecs.push_back(mk(0,0,1, 0,   0,1,0,0, 0,  0,  0, 0));
`endif
        vecs.push_back(mk(1,0,0, 0,   0,1,0,0, 0,  0,  0, 0));
        vecs.push_back(mk(0,1,0, 0,   0,1,0,0, 0,  0,  0, 0));
        vecs.push_back(mk(0,0,1, 5,   1,1,0,0, 5,  0,  0, 0));
        vecs.push_back(mk(0,1,1, 7,   1,1,0,0, 5,  0,  0, 0));
        vecs.push_back(mk(1,0,1, 7,   0,1,0,0, 0,  0,  0, 0));
        vecs.push_back(mk(0,0,1, 100, 1,1,0,0, 100,0,  0, 0));
        vecs.push_back(mk(0,0,1, 200, 2,1,0,0, 100,200,0, 0));
        vecs.push_back(mk(0,0,1, 7,   3,1,1,0, 100,200,7, 0));
        vecs.push_back(mk(1,0,0, 0,   0,1,0,0, 0,  0,  0, 0));
        vecs.push_back(mk(0,0,0, 0,   0,0,0,0, 0,  0,  0, 0));
        vecs.push_back(mk(0,0,0, 0,   0,0,0,0, 0,  0,  0, 0));
        vecs.push_back(mk(0,0,1, 1,   1,1,0,0, 1,  0,  0, 0));
        vecs.push_back(mk(0,0,1, 2,   2,1,0,0, 1,  2,  0, 0));
        vecs.push_back(mk(0,0,1, 31,  2,0,0,0, 1,  2,  0, 0));
        vecs.push_back(mk(0,0,1, 1,   3,1,1,0, 1,  2,  1, 0));
        vecs.push_back(mk(0,1,1, 0,   3,0,0,0, 1,  2,  1, 0));
        vecs.push_back(mk(0,1,0, 0,   4,0,0,1, 1,  2,  1, 3));
        vecs.push_back(mk(0,0,0, 0,   4,0,0,1, 1,  2,  1, 3));
        vecs.push_back(mk(1,0,1, 0,   0,1,0,0, 0,  0,  0, 0));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            CLR = vecs[i].clr;
            CE  = vecs[i].ce;
            EXE = vecs[i].exe;
            op  = vecs[i].op;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("state", i, 32'(state), 32'(e.st));
            chk("rst_s", i, 32'(rst_s), 32'(e.rs));
            chk("alu_start", i, 32'(alu_start), 32'(e.start));
            chk("result_valid", i, 32'(result_valid), 32'(e.valid));
            chk("reg_a", i, 32'(reg_a), 32'(e.a));
            chk("reg_b", i, 32'(reg_b), 32'(e.b));
            chk("reg_op", i, 32'(reg_op), 32'(e.opc));
            chk("result", i, 32'(result), 32'(e.res));
        end

        // reset while in the first S_CALC cycle
        idle_in();
        EXE = 1'b1; op = 16'd10;
        @(posedge clk); #1;
        op = 16'd20;
        @(posedge clk); #1;
        op = 16'd2;
        @(posedge clk); #1;
        chk("pre_rst_state", 100, 32'(state), 32'd3);
        chk("pre_rst_start", 100, 32'(alu_start), 32'd1);
        idle_in();
        EXE = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_in();
        chk("rst_state", 101, 32'(state), 32'd0);
        chk("rst_rst_s", 101, 32'(rst_s), 32'd0);
        chk("rst_start", 101, 32'(alu_start), 32'd0);
        chk("rst_valid", 101, 32'(result_valid), 32'd0);
        chk("rst_a", 101, 32'(reg_a), 32'd0);
        chk("rst_b", 101, 32'(reg_b), 32'd0);
        chk("rst_op", 101, 32'(reg_op), 32'd0);
        chk("rst_result", 101, 32'(result), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post_rst_start", 102 + k, 32'(alu_start), 32'd0);
            chk("post_rst_state", 102 + k, 32'(state), 32'd0);
            chk("post_rst_result", 102 + k, 32'(result), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
